// File: rtl/fft16_ctrl.sv
// fft16_ctrl -- serial-to-parallel frame controller for a 16-point FFT core.
//
// Collects 16 complex samples over an in_valid/in_ready handshake into an
// input buffer, presents the buffer in parallel to the core with a one-cycle
// fft_en pulse, captures the 16 result bins on fft_valid and streams them out
// over an out_valid/out_ready handshake. One frame is in flight at a time; the
// block does no arithmetic, data passes bit-exact at WIDTH bits.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   in_valid_i / in_ready_o           sample-input handshake
//   in_real_i, in_imag_i              input sample (WIDTH each)
//   fft_en_o                          start pulse to the core
//   fft_x_real_o, fft_x_imag_o        frame to the core, sample n at [n*WIDTH +: WIDTH]
//   fft_valid_i                       core result strobe (honoured only in WAIT)
//   fft_y_real_i, fft_y_imag_i        core results, bin k at [k*WIDTH +: WIDTH]
//   out_valid_o / out_ready_i         result-output handshake
//   out_real_o, out_imag_o            result bin (WIDTH each)
//   out_index_o, out_last_o           bin number, high with bin 15
//   busy_o                            high in every state except LOAD
//   err_o                             one-cycle timeout-abort pulse
//
// Optional feature: define FFT16_CTRL_TIMEOUT_EN to abort a frame when the
// core stays silent for TIMEOUT WAIT cycles. Without it err_o is tied 0.
module fft16_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WIDTH-1:0]      in_real_i,
  input  logic [WIDTH-1:0]      in_imag_i,
  output logic                  fft_en_o,
  output logic [16*WIDTH-1:0]   fft_x_real_o,
  output logic [16*WIDTH-1:0]   fft_x_imag_o,
  input  logic                  fft_valid_i,
  input  logic [16*WIDTH-1:0]   fft_y_real_i,
  input  logic [16*WIDTH-1:0]   fft_y_imag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH-1:0]      out_real_o,
  output logic [WIDTH-1:0]      out_imag_o,
  output logic [3:0]            out_index_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_START  = 2'd1,
    S_WAIT   = 2'd2,
    S_UNLOAD = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] wr_idx_q, wr_idx_d;
  logic [3:0] rd_idx_q, rd_idx_d;

  logic [WIDTH-1:0] ibuf_re_q [16];
  logic [WIDTH-1:0] ibuf_im_q [16];
  logic [WIDTH-1:0] obuf_re_q [16];
  logic [WIDTH-1:0] obuf_im_q [16];

  logic accept_s;
  logic xfer_s;
  logic capture_s;
  logic timeout_s;

  assign accept_s  = in_valid_i && in_ready_o;
  assign xfer_s    = out_valid_o && out_ready_i;
  // Core results are taken only while waiting for them; strobes elsewhere are dropped.
  assign capture_s = (state_q == S_WAIT) && fft_valid_i;

`ifdef FFT16_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

  // The counter is cleared in START so it reads 0 on the first WAIT cycle;
  // it therefore equals the number of WAIT cycles already elapsed.
  assign timeout_s = (state_q == S_WAIT) && !fft_valid_i && (tmo_cnt_q == CW'(TIMEOUT));

  // Timeout counter next state.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_START) begin
      tmo_cnt_d = '0;
    end else if ((state_q == S_WAIT) && !timeout_s) begin
      tmo_cnt_d = tmo_cnt_q + CW'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = |TIMEOUT;
  assign timeout_s        = 1'b0;
`endif

  // State and index registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_LOAD;
      wr_idx_q <= 4'd0;
      rd_idx_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Next-state logic; the 4-bit indices wrap from 15 to 0 on their own.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = accept_s ? (wr_idx_q + 4'd1) : wr_idx_q;
    rd_idx_d = xfer_s   ? (rd_idx_q + 4'd1) : rd_idx_q;
    case (state_q)
      S_LOAD: begin
        if (accept_s && (wr_idx_q == 4'd15)) begin
          state_d = S_START;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (capture_s) begin
          state_d = S_UNLOAD;
        end else if (timeout_s) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_UNLOAD: begin
        if (xfer_s && (rd_idx_q == 4'd15)) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_UNLOAD;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    in_ready_o  = (state_q == S_LOAD) && !rst_i;
    fft_en_o    = (state_q == S_START);
    out_valid_o = (state_q == S_UNLOAD);
    busy_o      = (state_q != S_LOAD);
    err_o       = timeout_s;
  end

  // Input and output sample buffers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 16; k++) begin
        ibuf_re_q[k] <= '0;
        ibuf_im_q[k] <= '0;
        obuf_re_q[k] <= '0;
        obuf_im_q[k] <= '0;
      end
    end else begin
      if (accept_s) begin
        ibuf_re_q[wr_idx_q] <= in_real_i;
        ibuf_im_q[wr_idx_q] <= in_imag_i;
      end
      if (capture_s) begin
        for (int k = 0; k < 16; k++) begin
          obuf_re_q[k] <= fft_y_real_i[k*WIDTH +: WIDTH];
          obuf_im_q[k] <= fft_y_imag_i[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // The core sees the input buffer directly, so the frame is stable until the next LOAD.
  for (genvar k = 0; k < 16; k++) begin : g_xbus
    assign fft_x_real_o[k*WIDTH +: WIDTH] = ibuf_re_q[k];
    assign fft_x_imag_o[k*WIDTH +: WIDTH] = ibuf_im_q[k];
  end

  assign out_real_o  = obuf_re_q[rd_idx_q];
  assign out_imag_o  = obuf_im_q[rd_idx_q];
  assign out_index_o = rd_idx_q;
  assign out_last_o  = out_valid_o && (rd_idx_q == 4'd15);

endmodule

// File: tb/tb_fft16_ctrl.sv
// Self-checking bench for fft16_ctrl: randomized sample streams, a core model
// with fixed latency, and a frame-level reference (loaded frame -> expected
// core input -> expected output bins) kept as packed frames.
module tb_fft16_ctrl;

  localparam int W   = 16;
  localparam int LAT = 4;

  typedef logic [255:0] val_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_real = '0;
  logic [W-1:0] in_imag = '0;
  logic         fft_en;
  logic [16*W-1:0] fft_x_real, fft_x_imag;
  logic         fft_valid = 1'b0;
  logic [16*W-1:0] fft_y_real = '0;
  logic [16*W-1:0] fft_y_imag = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_real, out_imag;
  logic [3:0]   out_index;
  logic         out_last;
  logic         busy;
  logic         err;

  fft16_ctrl #(.WIDTH(W), .TIMEOUT(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_real_i(in_real), .in_imag_i(in_imag),
    .fft_en_o(fft_en), .fft_x_real_o(fft_x_real), .fft_x_imag_o(fft_x_imag),
    .fft_valid_i(fft_valid), .fft_y_real_i(fft_y_real), .fft_y_imag_i(fft_y_imag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_real_o(out_real), .out_imag_o(out_imag),
    .out_index_o(out_index), .out_last_o(out_last),
    .busy_o(busy), .err_o(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: frame being loaded, frame handed to the core, expected output.
  logic [16*W-1:0] ld_re, ld_im;
  logic [16*W-1:0] exp_x_re, exp_x_im;
  logic [16*W-1:0] exp_out_re, exp_out_im;
  bit core_rev = 1'b0;
  bit core_off = 1'b0;
  int spur_req = 0;
  int spur_done = 0;

  task automatic check(input string tag, input val_t obs, input val_t expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [16*W-1:0] rand_frame();
    logic [16*W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Core transfer function used by the model: identity or bin reversal.
  function automatic logic [16*W-1:0] core_fn(input logic [16*W-1:0] x, input bit rev);
    logic [16*W-1:0] r;
    for (int k = 0; k < 16; k++) r[k*W +: W] = rev ? x[(15-k)*W +: W] : x[k*W +: W];
    return r;
  endfunction

  // Core model: captures the frame on fft_en, answers LAT cycles later, and
  // optionally injects stray strobes with garbage data when asked.
  logic [16*W-1:0] cap_re, cap_im;
  int lat = 0;
  always @(negedge clk) begin
    if (rst) begin
      lat = 0;
      fft_valid = 1'b0;
    end else if (fft_en) begin
      check("fft_x_real", val_t'(fft_x_real), val_t'(exp_x_re));
      check("fft_x_imag", val_t'(fft_x_imag), val_t'(exp_x_im));
      cap_re = fft_x_real;
      cap_im = fft_x_imag;
      lat = core_off ? 0 : LAT;
      fft_valid = 1'b0;
      fft_y_real = rand_frame();
      fft_y_imag = rand_frame();
    end else if (lat > 0) begin
      lat--;
      check("fft_x_hold", val_t'({fft_x_real, fft_x_imag}), val_t'({cap_re, cap_im}));
      if (lat == 0) begin
        fft_valid = 1'b1;
        fft_y_real = core_fn(cap_re, core_rev);
        fft_y_imag = core_fn(cap_im, core_rev);
      end else begin
        fft_valid = 1'b0;
        fft_y_real = rand_frame();
        fft_y_imag = rand_frame();
      end
    end else if (spur_req != spur_done) begin
      spur_done = spur_req;
      fft_valid = 1'b1;
      fft_y_real = rand_frame();
      fft_y_imag = rand_frame();
    end else begin
      fft_valid = 1'b0;
      fft_y_real = rand_frame();
      fft_y_imag = rand_frame();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input int kind, input int idx);
    case (kind)
      0: begin in_real = W'(idx); in_imag = W'(-idx); end
      2: begin in_real = 16'h1000; in_imag = 16'h1000; end
      default: begin in_real = W'($urandom()); in_imag = W'($urandom()); end
    endcase
  endtask

  // One full frame: load 16 samples, let the core answer, unload 16 bins.
  task automatic do_frame(input int kind, input bit gaps, input bit stalls,
                          input bit spur, input bit b2b);
    int sent = 0, got = 0, cyc = 0, en_cnt = 0, stall_n = 0, stall_bin = -1;
    bit acc, xfer, spur_l = 1'b0, spur_u = 1'b0;
    while (got < 16 && cyc < 1000) begin
      if (sent < 16 && (!gaps || $urandom_range(0, 2) != 0)) begin
        in_valid = 1'b1;
        set_sample(kind, sent);
      end else begin
        in_valid = 1'b0;
        in_real = W'($urandom());
        in_imag = W'($urandom());
      end
      out_ready = 1'b1;
      if (stalls && out_valid && (got == 3 || got == 15)) begin
        if (stall_bin != got) begin stall_bin = got; stall_n = 0; end
        if (stall_n < 5) begin out_ready = 1'b0; stall_n++; end
      end
      if (spur && !spur_l && sent == 5 && in_ready) begin spur_req++; spur_l = 1'b1; end
      if (spur && !spur_u && out_valid && !out_ready) begin spur_req++; spur_u = 1'b1; end
      if (b2b && cyc == 0) check("b2b_first_accept", val_t'(in_valid && in_ready), val_t'(1'b1));
      if (out_valid) begin
        check("out_real", val_t'(out_real), val_t'(exp_out_re[got*W +: W]));
        check("out_imag", val_t'(out_imag), val_t'(exp_out_im[got*W +: W]));
        check("out_index", val_t'(out_index), val_t'(got));
        check("out_last", val_t'(out_last), val_t'(got == 15));
        check("in_ready_unload", val_t'(in_ready), val_t'(1'b0));
        check("busy_unload", val_t'(busy), val_t'(1'b1));
      end
      if (fft_en) en_cnt++;
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      tick();
      if (acc) begin
        ld_re[sent*W +: W] = in_real;
        ld_im[sent*W +: W] = in_imag;
        sent++;
        if (sent == 16) begin
          exp_x_re = ld_re;
          exp_x_im = ld_im;
          exp_out_re = core_fn(ld_re, core_rev);
          exp_out_im = core_fn(ld_im, core_rev);
          check("fft_en_after_16th", val_t'(fft_en), val_t'(1'b1));
        end
      end
      if (xfer) got++;
      cyc++;
    end
    in_valid = 1'b0;
    check("frame_bins", val_t'(got), val_t'(16));
    check("fft_en_pulses", val_t'(en_cnt), val_t'(1));
    check("end_out_valid", val_t'(out_valid), val_t'(1'b0));
    check("end_busy", val_t'(busy), val_t'(1'b0));
    check("end_in_ready", val_t'(in_ready), val_t'(1'b1));
  endtask

  initial begin
    // Reset state.
    repeat (3) tick();
    check("rst_in_ready", val_t'(in_ready), val_t'(1'b0));
    check("rst_out_valid", val_t'(out_valid), val_t'(1'b0));
    check("rst_fft_en", val_t'(fft_en), val_t'(1'b0));
    check("rst_busy", val_t'(busy), val_t'(1'b0));
    check("rst_err", val_t'(err), val_t'(1'b0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", val_t'(in_ready), val_t'(1'b1));

    // Directed ramp with identity core.
    core_rev = 1'b0;
    do_frame(0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random data, input gaps, output stalls and stray core strobes.
    core_rev = 1'b1;
    for (int f = 0; f < 3; f++) do_frame(1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset after 9 accepted samples, then a constant frame.
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      set_sample(1, i);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", val_t'(in_ready), val_t'(1'b0));
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_busy", val_t'(busy), val_t'(1'b0));
    check("mid_rst_in_ready_after", val_t'(in_ready), val_t'(1'b1));
    core_rev = 1'b0;
    do_frame(2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Two back-to-back frames with out_ready held high.
    do_frame(1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_frame(1, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef FFT16_CTRL_TIMEOUT_EN
    // Silent core: expect an abort pulse after 32 WAIT cycles.
    begin
      int cyc = 0;
      core_off = 1'b1;
      for (int i = 0; i < 16; i++) begin
        in_valid = 1'b1;
        set_sample(1, i);
        ld_re[i*W +: W] = in_real;
        ld_im[i*W +: W] = in_imag;
        if (i == 15) begin exp_x_re = ld_re; exp_x_im = ld_im; end
        tick();
      end
      in_valid = 1'b0;
      check("tmo_fft_en", val_t'(fft_en), val_t'(1'b1));
      tick();
      while (!err && cyc < 100) begin
        check("tmo_no_out_valid", val_t'(out_valid), val_t'(1'b0));
        tick();
        cyc++;
      end
      check("tmo_err_cycle", val_t'(cyc), val_t'(32));
      tick();
      check("tmo_in_ready", val_t'(in_ready), val_t'(1'b1));
      check("tmo_err_pulse", val_t'(err), val_t'(1'b0));
      core_off = 1'b0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
